// File: rtl/servo_motion_scheduler_if.sv
// servo_motion_scheduler_if: valid/ready command channel carrying a channel select and a target angle code.
//   cmd_valid  source -> scheduler  command present
//   cmd_ready  scheduler -> source  command can be accepted this cycle
//   cmd_ch     source -> scheduler  0 = channel 1, 1 = channel 2
//   cmd_angle  source -> scheduler  requested angle code, unsigned
interface servo_motion_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_ch;
  logic [7:0] cmd_angle;
  modport master (output cmd_valid, cmd_ch, cmd_angle, input cmd_ready);
  modport slave (input cmd_valid, cmd_ch, cmd_angle, output cmd_ready);
endinterface

// File: rtl/servo_motion_scheduler.sv
// servo_motion_scheduler: frame-synchronous angle ramping for two SG-90 servo channels.
//   clk, rst_n          clock, asynchronous active-low reset
//   bus                 command channel (slave side)
//   abort               freeze both channels at their current angle
//   angle_1, angle_2    angle codes to the two SG_90 generators
//   busy_1, busy_2      channel is ramping
//   done                one-cycle completion pulse per channel, bit0 = channel 1
//   frame_tick          one-cycle pulse at the end of each PWM frame
module servo_motion_scheduler #(
  parameter int FRAME_CYCLES = 1000000,
  parameter int STEP_FRAMES  = 2,
  parameter int MIN_ANGLE    = 5,
  parameter int MAX_ANGLE    = 25
) (
  input  logic                           clk,
  input  logic                           rst_n,
  servo_motion_scheduler_if.slave        bus,
  input  logic                           abort,
  output logic [7:0]                     angle_1,
  output logic [7:0]                     angle_2,
  output logic                           busy_1,
  output logic                           busy_2,
  output logic [1:0]                     done,
  output logic                           frame_tick
);
  localparam int FW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
  localparam int SW = STEP_FRAMES > 1 ? $clog2(STEP_FRAMES) : 1;
  localparam logic [7:0] LO = 8'(MIN_ANGLE);
  localparam logic [7:0] HI = 8'(MAX_ANGLE);
  typedef enum logic {IDLE, RAMP} state_t;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic [SW-1:0] scnt;
  logic          step_en, rdy_q, accept;
  logic [7:0]    clamped;
  logic [1:0]    hit, step_ch, ev, done_nxt;
  state_t        state [2];
  state_t        state_nxt [2];
  logic [7:0]    angle [2];
  logic [7:0]    angle_nxt [2];
  logic [7:0]    target [2];
  logic [7:0]    target_nxt [2];
  assign fcnt_nxt = (fcnt == FW'(FRAME_CYCLES - 1)) ? '0 : fcnt + 1'b1;
  assign step_en = frame_tick && scnt == SW'(STEP_FRAMES - 1);
  // ready is registered but masked by abort so no command slips in while frozen
  assign bus.cmd_ready = rdy_q && !abort;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign clamped = bus.cmd_angle < LO ? LO : bus.cmd_angle > HI ? HI : bus.cmd_angle;
  assign hit = {accept && bus.cmd_ch, accept && !bus.cmd_ch};
  assign step_ch = {state[1] == RAMP, state[0] == RAMP} & {2{step_en}};
  assign ev = hit | step_ch;
  assign angle_1 = angle[0];
  assign angle_2 = angle[1];
  assign busy_1 = state[0] == RAMP;
  assign busy_2 = state[1] == RAMP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fcnt       <= '0;
      scnt       <= '0;
      frame_tick <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      fcnt       <= fcnt_nxt;
      frame_tick <= fcnt_nxt == FW'(FRAME_CYCLES - 1);
      if (frame_tick) scnt <= step_en ? '0 : scnt + 1'b1;
      rdy_q      <= !abort && !accept;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= '{IDLE, IDLE};
      angle  <= '{LO, LO};
      target <= '{LO, LO};
      done   <= 2'b00;
    end else begin
      state  <= state_nxt;
      angle  <= angle_nxt;
      target <= target_nxt;
      done   <= done_nxt;
    end
  // a step always uses the target held before this edge; a same-cycle accept
  // only replaces the target, so it steers from the following step onward
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      angle_nxt[i]  = abort ? angle[i] : step_ch[i] ? (target[i] > angle[i] ? angle[i] + 8'd1 : angle[i] - 8'd1) : angle[i];
      target_nxt[i] = abort ? angle[i] : hit[i] ? clamped : target[i];
      state_nxt[i]  = abort ? IDLE : !ev[i] ? state[i] : target_nxt[i] == angle_nxt[i] ? IDLE : RAMP;
      done_nxt[i]   = !abort && ev[i] && target_nxt[i] == angle_nxt[i];
    end
  end
endmodule

// File: tb/tb_servo_motion_scheduler.sv
// tb_servo_motion_scheduler: directed bench for servo_motion_scheduler with 10-cycle frames and 2-frame steps.
module tb_servo_motion_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] angle_1, angle_2;
  logic       busy_1, busy_2, frame_tick;
  logic [1:0] done;
  int         tests = 0;
  int         failed = 0;
  servo_motion_scheduler_if bus();
  servo_motion_scheduler #(.FRAME_CYCLES(10), .STEP_FRAMES(2), .MIN_ANGLE(5), .MAX_ANGLE(25)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .abort(abort),
    .angle_1(angle_1), .angle_2(angle_2), .busy_1(busy_1), .busy_2(busy_2),
    .done(done), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    abort = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
  task automatic send(input logic ch, input logic [7:0] a, output bit to);
    int n = 0;
    while (!bus.cmd_ready && n < 10) begin
      tick();
      n++;
    end
    to = !bus.cmd_ready;
    bus.cmd_valid = 1'b1;
    bus.cmd_ch = ch;
    bus.cmd_angle = a;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_angle(input logic ch, input int lim, output int cyc, output logic [1:0] ds, output bit to);
    logic [7:0] a0 = ch ? angle_2 : angle_1;
    cyc = 0;
    ds = 2'b00;
    to = 1'b1;
    while (to && cyc < lim) begin
      tick();
      cyc++;
      ds |= done;
      if ((ch ? angle_2 : angle_1) !== a0) to = 1'b0;
    end
  endtask
  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({angle_1, angle_2, busy_1, busy_2, done, bus.cmd_ready, frame_tick} !== {8'd5, 8'd5, 6'd0}) begin
      failed++;
      $display("FAIL reset_state got a1=%0d a2=%0d b=%b%b done=%b rdy=%b ft=%b want a1=5 a2=5 rest 0", angle_1, angle_2, busy_1, busy_2, done, bus.cmd_ready, frame_tick);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.cmd_ready !== 1'b1 || angle_1 !== 8'd5 || done !== 2'b00) begin
      failed++;
      $display("FAIL ready_after_reset got rdy=%b a1=%0d done=%b want rdy=1 a1=5 done=00", bus.cmd_ready, angle_1, done);
    end
    n = 0;
    while (!frame_tick && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n != 8) begin
      failed++;
      $display("FAIL first_frame_tick got %0d more cycles want 8", n);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_tick && n < 20);
    tests++;
    if (n != 10) begin
      failed++;
      $display("FAIL frame_period got %0d want 10", n);
    end
    tests++;
    if (angle_1 !== 8'd5 || angle_2 !== 8'd5 || busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
      failed++;
      $display("FAIL idle_hold got a1=%0d a2=%0d b=%b%b want 5 5 00", angle_1, angle_2, busy_1, busy_2);
    end
  endtask
  task automatic test_ramp;
    bit to;
    int cyc;
    logic [1:0] ds;
    send(1'b0, 8'd15, to);
    tests++;
    if (to || busy_1 !== 1'b1 || bus.cmd_ready !== 1'b0 || angle_1 !== 8'd5) begin
      failed++;
      $display("FAIL ramp_accept got to=%0d busy_1=%b rdy=%b a1=%0d want to=0 busy_1=1 rdy=0 a1=5", to, busy_1, bus.cmd_ready, angle_1);
    end
    tick();
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL ready_return got %b want 1", bus.cmd_ready);
    end
    for (int e = 6; e <= 15; e++) begin
      wait_angle(1'b0, 45, cyc, ds, to);
      tests++;
      if (to || angle_1 !== e[7:0] || angle_2 !== 8'd5) begin
        failed++;
        $display("FAIL ramp_step got to=%0d a1=%0d a2=%0d want a1=%0d a2=5", to, angle_1, angle_2, e);
      end
      if (e > 6) begin
        tests++;
        if (cyc != 20) begin
          failed++;
          $display("FAIL step_spacing got %0d cycles want 20 (a1=%0d)", cyc, e);
        end
      end
      tests++;
      if ({busy_1, ds} !== (e == 15 ? 3'b001 : 3'b100)) begin
        failed++;
        $display("FAIL ramp_status at a1=%0d got busy_1=%b done_seen=%b want %b", e, busy_1, ds, (e == 15 ? 3'b001 : 3'b100));
      end
    end
    tick();
    tests++;
    if (done !== 2'b00 || busy_1 !== 1'b0) begin
      failed++;
      $display("FAIL done_one_cycle got done=%b busy_1=%b want 00 0", done, busy_1);
    end
  endtask
  task automatic test_clamp;
    bit to;
    int cyc;
    logic [1:0] ds;
    send(1'b1, 8'd40, to);
    tests++;
    if (to || busy_2 !== 1'b1 || busy_1 !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      failed++;
      $display("FAIL clamp_hi_accept got to=%0d b2=%b b1=%b rdy=%b want 0 1 0 0", to, busy_2, busy_1, bus.cmd_ready);
    end
    for (int e = 6; e <= 25; e++) begin
      wait_angle(1'b1, 45, cyc, ds, to);
      tests++;
      if (to || angle_2 !== e[7:0] || angle_1 !== 8'd15 || ds !== (e == 25 ? 2'b10 : 2'b00)) begin
        failed++;
        $display("FAIL clamp_up got to=%0d a2=%0d a1=%0d done_seen=%b want a2=%0d a1=15", to, angle_2, angle_1, ds, e);
      end
    end
    wait_angle(1'b1, 45, cyc, ds, to);
    tests++;
    if (!to || angle_2 !== 8'd25 || ds !== 2'b00 || busy_2 !== 1'b0) begin
      failed++;
      $display("FAIL clamp_hi_stop got moved=%0d a2=%0d done_seen=%b b2=%b want a2=25 idle", !to, angle_2, ds, busy_2);
    end
    send(1'b1, 8'd0, to);
    tests++;
    if (to || busy_2 !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      failed++;
      $display("FAIL clamp_lo_accept got to=%0d b2=%b rdy=%b want 0 1 0", to, busy_2, bus.cmd_ready);
    end
    for (int e = 24; e >= 5; e--) begin
      wait_angle(1'b1, 45, cyc, ds, to);
      tests++;
      if (to || angle_2 !== e[7:0] || ds !== (e == 5 ? 2'b10 : 2'b00)) begin
        failed++;
        $display("FAIL clamp_down got to=%0d a2=%0d done_seen=%b want a2=%0d", to, angle_2, ds, e);
      end
    end
    wait_angle(1'b1, 45, cyc, ds, to);
    tests++;
    if (!to || angle_2 !== 8'd5) begin
      failed++;
      $display("FAIL clamp_lo_stop got moved=%0d a2=%0d want a2=5 still", !to, angle_2);
    end
  endtask
  task automatic test_retarget;
    bit to;
    int cyc;
    logic [1:0] ds;
    do_reset();
    send(1'b0, 8'd20, to);
    for (int e = 6; e <= 10; e++) begin
      wait_angle(1'b0, 45, cyc, ds, to);
      tests++;
      if (to || angle_1 !== e[7:0]) begin
        failed++;
        $display("FAIL retarget_up got to=%0d a1=%0d want %0d", to, angle_1, e);
      end
    end
    send(1'b0, 8'd7, to);
    tests++;
    if (to || busy_1 !== 1'b1 || done !== 2'b00 || bus.cmd_ready !== 1'b0) begin
      failed++;
      $display("FAIL retarget_accept got to=%0d b1=%b done=%b rdy=%b want 0 1 00 0", to, busy_1, done, bus.cmd_ready);
    end
    for (int e = 9; e >= 7; e--) begin
      wait_angle(1'b0, 45, cyc, ds, to);
      tests++;
      if (to || angle_1 !== e[7:0] || ds !== (e == 7 ? 2'b01 : 2'b00) || busy_1 !== (e != 7)) begin
        failed++;
        $display("FAIL retarget_down got to=%0d a1=%0d done_seen=%b b1=%b want a1=%0d", to, angle_1, ds, busy_1, e);
      end
    end
    wait_angle(1'b0, 45, cyc, ds, to);
    tests++;
    if (!to || ds !== 2'b00 || angle_1 !== 8'd7) begin
      failed++;
      $display("FAIL retarget_settle got moved=%0d done_seen=%b a1=%0d want still at 7 no done", !to, ds, angle_1);
    end
    send(1'b0, 8'd7, to);
    tests++;
    if (to || done !== 2'b01 || busy_1 !== 1'b0 || angle_1 !== 8'd7) begin
      failed++;
      $display("FAIL same_angle got to=%0d done=%b b1=%b a1=%0d want done=01 b1=0 a1=7", to, done, busy_1, angle_1);
    end
    tick();
    tests++;
    if (done !== 2'b00 || busy_1 !== 1'b0) begin
      failed++;
      $display("FAIL same_angle_after got done=%b b1=%b want 00 0", done, busy_1);
    end
    send(1'b1, 8'd3, to);
    tests++;
    if (to || done !== 2'b10 || busy_2 !== 1'b0 || angle_2 !== 8'd5) begin
      failed++;
      $display("FAIL clamp_same got to=%0d done=%b b2=%b a2=%0d want done=10 b2=0 a2=5", to, done, busy_2, angle_2);
    end
  endtask
  task automatic test_abort;
    bit to;
    int cyc;
    logic [1:0] ds;
    logic seen_rdy, seen_busy, moved;
    do_reset();
    send(1'b0, 8'd20, to);
    for (int e = 6; e <= 12; e++) begin
      wait_angle(1'b0, 45, cyc, ds, to);
      tests++;
      if (to || angle_1 !== e[7:0]) begin
        failed++;
        $display("FAIL abort_ramp got to=%0d a1=%0d want %0d", to, angle_1, e);
      end
    end
    abort = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_ch = 1'b0;
    bus.cmd_angle = 8'd25;
    #1;
    tests++;
    if (bus.cmd_ready !== 1'b0) begin
      failed++;
      $display("FAIL abort_ready got %b want 0", bus.cmd_ready);
    end
    ds = 2'b00;
    seen_rdy = 1'b0;
    seen_busy = 1'b0;
    moved = 1'b0;
    repeat (45) begin
      tick();
      ds |= done;
      seen_rdy |= bus.cmd_ready;
      seen_busy |= busy_1;
      moved |= angle_1 !== 8'd12;
    end
    tests++;
    if (moved || seen_busy || seen_rdy || ds !== 2'b00) begin
      failed++;
      $display("FAIL abort_hold got moved=%b busy=%b rdy=%b done_seen=%b want all 0", moved, seen_busy, seen_rdy, ds);
    end
    abort = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    tests++;
    if (bus.cmd_ready !== 1'b0) begin
      failed++;
      $display("FAIL abort_fall_ready got %b want 0", bus.cmd_ready);
    end
    tick();
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL abort_ready_return got %b want 1", bus.cmd_ready);
    end
    wait_angle(1'b0, 45, cyc, ds, to);
    tests++;
    if (!to || angle_1 !== 8'd12 || busy_1 !== 1'b0 || ds !== 2'b00) begin
      failed++;
      $display("FAIL abort_no_resume got moved=%0d a1=%0d b1=%b done_seen=%b want a1=12 idle", !to, angle_1, busy_1, ds);
    end
  endtask
  task automatic test_async_reset;
    bit to;
    int cyc;
    logic [1:0] ds;
    do_reset();
    send(1'b0, 8'd20, to);
    for (int e = 6; e <= 14; e++) wait_angle(1'b0, 45, cyc, ds, to);
    tests++;
    if (angle_1 !== 8'd14 || busy_1 !== 1'b1) begin
      failed++;
      $display("FAIL async_pre got a1=%0d b1=%b want 14 1", angle_1, busy_1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({angle_1, angle_2, busy_1, busy_2, done, bus.cmd_ready, frame_tick} !== {8'd5, 8'd5, 6'd0}) begin
      failed++;
      $display("FAIL async_reset got a1=%0d a2=%0d b=%b%b done=%b rdy=%b ft=%b want a1=5 a2=5 rest 0", angle_1, angle_2, busy_1, busy_2, done, bus.cmd_ready, frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wait_angle(1'b0, 45, cyc, ds, to);
    tests++;
    if (!to || angle_1 !== 8'd5 || busy_1 !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL async_no_resume got moved=%0d a1=%0d b1=%b rdy=%b want a1=5 b1=0 rdy=1", !to, angle_1, busy_1, bus.cmd_ready);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_ch = 1'b0;
    bus.cmd_angle = 8'd0;
    test_reset();
    test_ramp();
    test_clamp();
    test_retarget();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
